mux_nx1_arb: RTL and testbench

Parametrised successor to the combinational 2-to-1 data-flow mux: an N-channel, W-bit registered multiplexer with per-channel valid/ready handshakes and a built-in arbiter (fixed-priority or round-robin, selectable at run time). It sits between several producers and one consumer. Selection is by arbitration instead of an external select line, and the winning word is held in a one-entry output register until the consumer accepts it.

---
 rtl/mux_nx1_arb_pkg.sv | 18 +
 rtl/mux_nx1_arb_grant_rr.sv | 44 ++++
 rtl/mux_nx1_arb.sv | 78 +++++++
 tb/tb_mux_nx1_arb.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mux_nx1_arb_pkg.sv
// Shared constants and helpers for the N-to-1 arbitrated output mux.
package mux_nx1_arb_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Ceiling log2 for sizing channel indices; callers guarantee value >= 2.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
      else result = result;
    end
    return result;
  endfunction

endpackage

// File: rtl/mux_nx1_arb_grant_rr.sv
// Combinational arbiter: fixed priority from channel 0, or round-robin starting at ptr.
module mux_nx1_arb_grant_rr
  import mux_nx1_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             rr_mode,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] winner,
  output logic             any
);

  logic [N-1:0]     grant_s;
  logic [SEL_W-1:0] winner_s;
  logic             found_s;

  // Scan channels in priority order and keep the first requester found.
  always_comb begin
    int pos;
    int idx;
    grant_s  = '0;
    winner_s = '0;
    found_s  = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos = (rr_mode == MODE_RR) ? int'(ptr) + k : k;
      idx = (pos >= N) ? pos - N : pos;
      if (!found_s && req[idx]) begin
        grant_s[idx] = 1'b1;
        winner_s     = SEL_W'(idx);
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign grant  = grant_s;
  assign winner = winner_s;
  assign any    = found_s;

endmodule

// File: rtl/mux_nx1_arb.sv
// N-channel registered multiplexer with valid/ready handshakes and a run-time
// selectable fixed-priority / round-robin arbiter feeding a one-entry output register.
module mux_nx1_arb
  import mux_nx1_arb_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int SEL_W = clog2(N)
) (
  input  logic               clock,
  input  logic               reset_b,
  input  logic               rr_mode,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_chan,
  input  logic               out_ready
);

  logic [N-1:0]     grant_s;
  logic [SEL_W-1:0] win_s;
  logic             any_s;
  logic             load_en_s;
  logic [SEL_W-1:0] next_ptr_s;
  logic [WIDTH-1:0] win_data_s;

  logic [SEL_W-1:0] ptr_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic [SEL_W-1:0] out_chan_r;

  mux_nx1_arb_grant_rr #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_grant (
    .req     (in_valid),
    .ptr     (ptr_r),
    .rr_mode (rr_mode),
    .grant   (grant_s),
    .winner  (win_s),
    .any     (any_s)
  );

  // The register accepts a new word when empty or being drained this cycle.
  assign load_en_s  = !out_valid_r || out_ready;
  assign in_ready   = grant_s & {N{load_en_s & reset_b}};
  assign win_data_s = in_data[int'(win_s)*WIDTH +: WIDTH];
  assign next_ptr_s = (win_s == SEL_W'(N-1)) ? {SEL_W{1'b0}} : win_s + SEL_W'(1);

  // Output register and round-robin pointer; a stalled output freezes everything.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      ptr_r       <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_chan_r  <= '0;
    end else if (load_en_s) begin
      if (any_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= win_data_s;
        out_chan_r  <= win_s;
        if (rr_mode == MODE_RR) ptr_r <= next_ptr_s;
        else ptr_r <= ptr_r;
      end else begin
        out_valid_r <= 1'b0;
      end
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_chan  = out_chan_r;

endmodule

// File: tb/tb_mux_nx1_arb.sv
// Directed bench: one 4-channel and one 3-channel instance with hand-computed expectations.
module tb_mux_nx1_arb;

  logic        clock;
  logic        reset_b;
  logic        rr_mode;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_ready;

  logic        reset3_b;
  logic        rr_mode3;
  logic [2:0]  in_valid3;
  logic [23:0] in_data3;
  logic [2:0]  in_ready3;
  logic        out_valid3;
  logic [7:0]  out_data3;
  logic [1:0]  out_chan3;
  logic        out_ready3;

  int total_cnt = 0;
  int bad_cnt   = 0;

  mux_nx1_arb #(.WIDTH(8), .N(4)) u_dut (
    .clock     (clock),
    .reset_b   (reset_b),
    .rr_mode   (rr_mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_ready (out_ready)
  );

  mux_nx1_arb #(.WIDTH(8), .N(3)) u_dut3 (
    .clock     (clock),
    .reset_b   (reset3_b),
    .rr_mode   (rr_mode3),
    .in_valid  (in_valid3),
    .in_data   (in_data3),
    .in_ready  (in_ready3),
    .out_valid (out_valid3),
    .out_data  (out_data3),
    .out_chan  (out_chan3),
    .out_ready (out_ready3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Check a 4-channel load: in_ready before the edge, held word after it.
  task automatic load4(input string tag, input logic [3:0] rdy, input logic [1:0] ch,
                       input logic [7:0] dat);
    chk({tag, "_rdy"}, 32'(in_ready), 32'(rdy));
    tick();
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_chan"}, 32'(out_chan), 32'(ch));
    chk({tag, "_data"}, 32'(out_data), 32'(dat));
  endtask

  task automatic load3(input string tag, input logic [2:0] rdy, input logic [1:0] ch,
                       input logic [7:0] dat);
    chk({tag, "_rdy"}, 32'(in_ready3), 32'(rdy));
    tick();
    chk({tag, "_vld"}, 32'(out_valid3), 32'd1);
    chk({tag, "_chan"}, 32'(out_chan3), 32'(ch));
    chk({tag, "_data"}, 32'(out_data3), 32'(dat));
  endtask

  initial begin
    reset_b    = 1'b0;
    rr_mode    = 1'b1;
    in_valid   = 4'b1111;
    in_data    = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    out_ready  = 1'b1;
    reset3_b   = 1'b0;
    rr_mode3   = 1'b1;
    in_valid3  = 3'b000;
    in_data3   = {8'hC2, 8'hC1, 8'hC0};
    out_ready3 = 1'b1;

    // Reset with every channel requesting.
    tick();
    tick();
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_chan", 32'(out_chan), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd0);

    // Round-robin rotation 0,1,2,3,0 starting right after release.
    reset_b  = 1'b1;
    reset3_b = 1'b1;
    #1;
    load4("rr0", 4'b0001, 2'd0, 8'hA0);
    load4("rr1", 4'b0010, 2'd1, 8'hA1);
    load4("rr2", 4'b0100, 2'd2, 8'hA2);
    load4("rr3", 4'b1000, 2'd3, 8'hA3);
    load4("rr4", 4'b0001, 2'd0, 8'hA0);

    // Fixed priority with ch1 and ch2 requesting: ch1 always wins.
    rr_mode  = 1'b0;
    in_valid = 4'b0110;
    #1;
    load4("fx0", 4'b0010, 2'd1, 8'hA1);
    load4("fx1", 4'b0010, 2'd1, 8'hA1);
    load4("fx2", 4'b0010, 2'd1, 8'hA1);

    // Pointer was left at 1 by the last round-robin load, untouched by fixed mode.
    rr_mode  = 1'b1;
    in_valid = 4'b1111;
    in_data  = {8'hA3, 8'h5A, 8'hA1, 8'hA0};
    #1;
    load4("ptr_kept", 4'b0010, 2'd1, 8'hA1);
    load4("bp_load", 4'b0100, 2'd2, 8'h5A);

    // Backpressure: three stalled cycles, word and channel stay put.
    out_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_rdy", 32'(in_ready), 32'd0);
      in_data[15:8] = 8'h00;
      tick();
      chk("bp_vld", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'h5A);
      chk("bp_chan", 32'(out_chan), 32'd2);
    end
    out_ready = 1'b1;
    #1;
    load4("bp_release", 4'b1000, 2'd3, 8'hA3);

    // Drain with nobody requesting empties the register.
    in_valid = 4'b0000;
    #1;
    chk("drain_rdy", 32'(in_ready), 32'd0);
    tick();
    chk("drain_vld", 32'(out_valid), 32'd0);

    // Odd channel count: only ch2, then only ch0, then all (pointer now at 1).
    in_valid3 = 3'b100;
    #1;
    load3("n3_ch2", 3'b100, 2'd2, 8'hC2);
    in_valid3 = 3'b001;
    #1;
    load3("n3_ch0", 3'b001, 2'd0, 8'hC0);
    in_valid3 = 3'b111;
    #1;
    load3("n3_ptr1", 3'b010, 2'd1, 8'hC1);
    load3("n3_ch2b", 3'b100, 2'd2, 8'hC2);

    // Asynchronous reset away from any clock edge clears the held word at once.
    #2;
    reset3_b = 1'b0;
    #1;
    chk("n3_arst_vld", 32'(out_valid3), 32'd0);
    chk("n3_arst_data", 32'(out_data3), 32'd0);
    chk("n3_arst_rdy", 32'(in_ready3), 32'd0);
    tick();
    reset3_b = 1'b1;
    #1;
    load3("n3_after", 3'b001, 2'd0, 8'hC0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
